// File: rtl/tape_pulse_gen_if.sv
// Byte stream from the tape loader into tape_pulse_gen.
// The master drives s_data/s_valid/s_last. The slave returns s_ready.
interface tape_pulse_gen_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/tape_pulse_gen.sv
// ZX Spectrum standard-speed tape waveform generator: pilot, sync, data and optional pause.
// Pulse timing counts T-states on ce_3m5. Bytes arrive through a one-entry buffer.
// Optional feature: define TAPE_PAUSE_EN to add the post-block silence (PAUSE state, 22-bit counter).
module tape_pulse_gen #(
  parameter int unsigned PILOT_T    = 2168,
  parameter int unsigned SYNC1_T    = 667,
  parameter int unsigned SYNC2_T    = 735,
  parameter int unsigned BIT0_T     = 855,
  parameter int unsigned BIT1_T     = 1710,
  parameter int unsigned PILOT_HDR  = 8063,
  parameter int unsigned PILOT_DATA = 3223
`ifdef TAPE_PAUSE_EN
  , parameter int unsigned PAUSE_T  = 3500000
`endif
) (
  input  logic                clk_peripheral,
  input  logic                reset_n,
  input  logic                ce_3m5,
  input  logic                start,
  tape_pulse_gen_if.slave     bus,
  output logic                tape_out,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PCNT_W = 16;
`ifdef TAPE_PAUSE_EN
  localparam int unsigned PAUSE_W = 22;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_PILOT,
    S_SYNC1,
    S_SYNC2,
    S_DATA,
`ifdef TAPE_PAUSE_EN
    S_PAUSE
`else
    S_END
`endif
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PCNT_W-1:0] pil, pil_n;
  logic [7:0]        sh, sh_n;
  logic              sh_last, sh_last_n;
  logic [2:0]        bit_idx, bit_n;
  logic              half, half_n;
  logic [7:0]        buf_data, buf_data_n;
  logic              buf_last, buf_last_n;
  logic              buf_full, buf_full_n;
  logic              last_seen, last_seen_n;
  logic              tape_n, busy_n, done_n, err_n;
  logic              pulse_end, counting, accept;
`ifdef TAPE_PAUSE_EN
  logic [PAUSE_W-1:0] pause_cnt, pause_n;
`endif

  // Half-period reload value for a data bit
  function automatic logic [CNT_W-1:0] bit_len(input logic b);
    return b ? CNT_W'(BIT1_T - 1) : CNT_W'(BIT0_T - 1);
  endfunction

  // The buffer accepts a byte only while a block runs, the buffer is empty and the final byte has not arrived
  assign bus.s_ready = busy & ~buf_full & ~last_seen;

  // Next-state, pulse engine, and byte buffer
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pil_n       = pil;
    sh_n        = sh;
    sh_last_n   = sh_last;
    bit_n       = bit_idx;
    half_n      = half;
    buf_data_n  = buf_data;
    buf_last_n  = buf_last;
    buf_full_n  = buf_full;
    last_seen_n = last_seen;
    tape_n      = tape_out;
    busy_n      = busy;
    done_n      = 1'b0;
    err_n       = 1'b0;
`ifdef TAPE_PAUSE_EN
    pause_n     = pause_cnt;
`endif

    accept    = bus.s_valid & bus.s_ready;
    pulse_end = ce_3m5 && (cnt == '0);
    counting  = (state == S_PILOT) || (state == S_SYNC1) ||
                (state == S_SYNC2) || (state == S_DATA);

    if (accept) begin
      buf_data_n = bus.s_data;
      buf_last_n = bus.s_last;
      buf_full_n = 1'b1;
      if (bus.s_last) last_seen_n = 1'b1;
    end

    if (counting && ce_3m5 && (cnt != '0)) cnt_n = cnt - CNT_W'(1);

    case (state)
      S_IDLE: begin
        tape_n = 1'b0;
        if (start) begin
          state_n     = S_FLAG;
          busy_n      = 1'b1;
          last_seen_n = 1'b0;
          buf_full_n  = 1'b0;
        end
      end
      S_FLAG: begin
        if (buf_full) begin
          sh_n       = buf_data;
          sh_last_n  = buf_last;
          buf_full_n = 1'b0;
          pil_n      = buf_data[7] ? PCNT_W'(PILOT_DATA) : PCNT_W'(PILOT_HDR);
          cnt_n      = '0;
          state_n    = S_PILOT;
        end
      end
      S_PILOT: begin
        if (pulse_end) begin
          tape_n = ~tape_out;
          if (pil != '0) begin
            pil_n = pil - PCNT_W'(1);
            cnt_n = CNT_W'(PILOT_T - 1);
          end else begin
            cnt_n   = CNT_W'(SYNC1_T - 1);
            state_n = S_SYNC1;
          end
        end
      end
      S_SYNC1: begin
        if (pulse_end) begin
          tape_n  = ~tape_out;
          cnt_n   = CNT_W'(SYNC2_T - 1);
          state_n = S_SYNC2;
        end
      end
      S_SYNC2: begin
        if (pulse_end) begin
          tape_n  = ~tape_out;
          cnt_n   = bit_len(sh[7]);
          bit_n   = 3'd7;
          half_n  = 1'b0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (pulse_end) begin
          if (!half) begin
            tape_n = ~tape_out;
            half_n = 1'b1;
            cnt_n  = bit_len(sh[bit_idx]);
          end else if (bit_idx != 3'd0) begin
            tape_n = ~tape_out;
            half_n = 1'b0;
            bit_n  = bit_idx - 3'd1;
            cnt_n  = bit_len(sh[bit_idx - 3'd1]);
          end else if (sh_last) begin
            // The final inversion closes the last pulse
            tape_n = ~tape_out;
`ifdef TAPE_PAUSE_EN
            pause_n = PAUSE_W'(PAUSE_T - 1);
            state_n = S_PAUSE;
`else
            state_n = S_END;
`endif
          end else if (buf_full) begin
            sh_n       = buf_data;
            sh_last_n  = buf_last;
            buf_full_n = 1'b0;
            tape_n     = ~tape_out;
            half_n     = 1'b0;
            bit_n      = 3'd7;
            cnt_n      = bit_len(buf_data[7]);
          end else begin
            // Underrun: abort the block at the byte boundary
            tape_n  = 1'b0;
            busy_n  = 1'b0;
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
`ifdef TAPE_PAUSE_EN
      S_PAUSE: begin
        tape_n = 1'b0;
        if (ce_3m5) begin
          if (pause_cnt == '0) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_IDLE;
          end else begin
            pause_n = pause_cnt - PAUSE_W'(1);
          end
        end
      end
`else
      S_END: begin
        tape_n  = 1'b0;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_peripheral) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pil       <= '0;
      sh        <= '0;
      sh_last   <= 1'b0;
      bit_idx   <= '0;
      half      <= 1'b0;
      buf_data  <= '0;
      buf_last  <= 1'b0;
      buf_full  <= 1'b0;
      last_seen <= 1'b0;
      tape_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef TAPE_PAUSE_EN
      pause_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pil       <= pil_n;
      sh        <= sh_n;
      sh_last   <= sh_last_n;
      bit_idx   <= bit_n;
      half      <= half_n;
      buf_data  <= buf_data_n;
      buf_last  <= buf_last_n;
      buf_full  <= buf_full_n;
      last_seen <= last_seen_n;
      tape_out  <= tape_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
`ifdef TAPE_PAUSE_EN
      pause_cnt <= pause_n;
`endif
    end
  end

endmodule

// File: tb/tb_tape_pulse_gen.sv
// Scoreboard bench for tape_pulse_gen, using shortened pulse lengths.
// Expected pulse lengths and block endings are queued at launch.
// A monitor pops and checks them on every tape_out change and every done/err pulse.
module tb_tape_pulse_gen;
  localparam int unsigned P_PILOT = 6;
  localparam int unsigned P_SYNC1 = 3;
  localparam int unsigned P_SYNC2 = 4;
  localparam int unsigned P_BIT0  = 2;
  localparam int unsigned P_BIT1  = 5;
  localparam int unsigned P_HDR   = 5;
  localparam int unsigned P_DATA  = 3;
  localparam int unsigned P_PAUSE = 10;

  logic clk = 1'b0;
  logic reset_n, ce, start;
  logic tape_out, busy, done, err;

  tape_pulse_gen_if bus ();

  tape_pulse_gen #(
    .PILOT_T(P_PILOT), .SYNC1_T(P_SYNC1), .SYNC2_T(P_SYNC2),
    .BIT0_T(P_BIT0), .BIT1_T(P_BIT1), .PILOT_HDR(P_HDR), .PILOT_DATA(P_DATA)
`ifdef TAPE_PAUSE_EN
    , .PAUSE_T(P_PAUSE)
`endif
  ) dut (
    .clk_peripheral(clk),
    .reset_n(reset_n),
    .ce_3m5(ce),
    .start(start),
    .bus(bus.slave),
    .tape_out(tape_out),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         pulse_q[$];
  int         term_q[$];
  logic [7:0] blk[$];
  logic       mon_en = 1'b0;
  logic       arm = 1'b0;
  logic       prev_tape = 1'b0;
  logic       ce_en = 1'b1;
  int         ce_div = 0;
  int         ticks = 0;
  int         edge_cnt = 0;
  int         term_cnt = 0;
  longint     cyc = 0;
  longint     last_edge_cyc = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bit_len(input logic b);
    return b ? P_BIT1 : P_BIT0;
  endfunction

  // T-state enable: one clk in four, gated for the freeze test
  always @(negedge clk) begin
    ce = ce_en && (ce_div == 3);
    ce_div = (ce_div + 1) % 4;
  end

  // Monitor: measure pulse lengths in ce ticks and check block terminations
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!mon_en) begin
      prev_tape = tape_out;
    end else begin
      if (ce) ticks++;
      if (tape_out !== prev_tape) begin
        if (arm) begin
          arm = 1'b0;
          chk("first_rise", tape_out, 1);
        end else if (pulse_q.size() == 0) begin
          chk("forced_low", tape_out, 0);
        end else begin
          chk("pulse_len", ticks, pulse_q.pop_front());
        end
        ticks = 0;
        edge_cnt++;
        last_edge_cyc = cyc;
        prev_tape = tape_out;
      end
      if (done || err) begin
        chk("term_excl", done && err, 0);
        chk("term_kind", done ? 1 : 2, (term_q.size() != 0) ? term_q.pop_front() : 0);
        chk("term_busy", busy, 0);
        chk("term_tape", tape_out, 0);
        chk("term_pulses_left", pulse_q.size(), 0);
        if (done) begin
`ifdef TAPE_PAUSE_EN
          chk("pause_ticks", ticks, P_PAUSE);
`else
          chk("done_latency", cyc - last_edge_cyc, 1);
`endif
        end
        term_cnt++;
      end
    end
  end

  // Present one byte and hold it until accepted; called at a negedge
  task automatic feed(input logic [7:0] b, input logic last);
    logic ok;
    ok = 1'b0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    for (int k = 0; k < 5000; k++) begin
      if (bus.s_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("byte_accept", ok, 1);
  endtask

  // Queue the expected waveform for blk, start the block and feed its bytes
  task automatic launch(input logic want_err);
    int n;
    n = blk[0][7] ? P_DATA : P_HDR;
    for (int i = 0; i < n; i++) pulse_q.push_back(P_PILOT);
    pulse_q.push_back(P_SYNC1);
    pulse_q.push_back(P_SYNC2);
    for (int i = 0; i < blk.size(); i++)
      for (int b = 7; b >= 0; b--) begin
        pulse_q.push_back(bit_len(blk[i][b]));
        pulse_q.push_back(bit_len(blk[i][b]));
      end
    term_q.push_back(want_err ? 2 : 1);
    arm = 1'b1;
    edge_cnt = 0;
    ticks = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < blk.size(); i++)
      feed(blk[i], !want_err && (i == blk.size() - 1));
  endtask

  task automatic wait_edges(input int n);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (edge_cnt >= n) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("edge_wait", found, 1);
  endtask

  task automatic wait_term(input int n);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (term_cnt >= n) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("term_wait", found, 1);
  endtask

  initial begin
    logic t0;
    int   e0;
    reset_n     = 1'b0;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tape", tape_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", bus.s_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Header block: flag 00, then FF, then 01 as the last byte
    blk = '{8'h00, 8'hFF, 8'h01};
    launch(1'b0);
    wait_term(1);

    // Data block with the flag as the only byte; start pulse mid-pilot; ce freeze
    blk = '{8'hFF};
    launch(1'b0);
    chk("ready_after_last", bus.s_ready, 0);
    wait_edges(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored", busy, 1);
    wait_edges(3);
    ce_en = 1'b0;
    repeat (2) @(negedge clk);
    t0 = tape_out;
    e0 = edge_cnt;
    repeat (100) @(negedge clk);
    chk("freeze_level", tape_out, t0);
    chk("freeze_edges", edge_cnt, e0);
    chk("freeze_busy", busy, 1);
    ce_en = 1'b1;
    wait_term(2);

    // Underrun: only the flag byte, never marked last
    blk = '{8'h00};
    launch(1'b1);
    wait_term(3);
    chk("underrun_ready", bus.s_ready, 0);

    // Reset pulse during SYNC2, then a full block
    blk = '{8'h00, 8'h01};
    launch(1'b0);
    wait_edges(P_HDR + 2);
    reset_n = 1'b0;
    mon_en  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_tape", tape_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ready", bus.s_ready, 0);
    pulse_q.delete();
    term_q.delete();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    blk = '{8'h00, 8'hA5};
    launch(1'b0);
    wait_term(4);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
